dmem_access_ctrl: RTL and testbench

//  Memory-stage controller for the 32-bit MIPS datapath; the consumer of the main control

---
 rtl/dmem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: turns decoded lw/sw into a req/ready handshake with data
// memory, stalls upstream until completion and registers the write-back result.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         dest_l;
    logic               m2r_l;
    logic               rw_l;

    logic               aligned;
    logic               accept;
    logic               illegal;
    logic               rtype_wb;
    logic               abort;

    // Decode of the EX-stage request and the ACCESS-state abort condition
    always_comb begin
        aligned  = 1'b0;
        accept   = 1'b0;
        illegal  = 1'b0;
        rtype_wb = 1'b0;
        abort    = 1'b0;
        stall    = 1'b0;

        aligned  = (alu_result[1:0] == 2'b00);
        accept   = ex_valid & (MemRead ^ MemWrite) & aligned;
        illegal  = ex_valid & ((MemRead & MemWrite) | ((MemRead | MemWrite) & !aligned));
        rtype_wb = ex_valid & !MemRead & !MemWrite & RegWrite;
        abort    = (state == ACCESS) & !mem_ready & (cnt == CNT_W'(TIMEOUT - 1));

        if (state == IDLE) begin
            stall = accept;
        end else begin
            stall = !mem_ready & !abort;
        end
    end

    // FSM, request latches and write-back registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dest_l    <= '0;
            m2r_l     <= 1'b0;
            rw_l      <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            mem_err   <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ACCESS;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= alu_result;
                        mem_wdata <= store_data;
                        dest_l    <= dest_reg;
                        m2r_l     <= MemtoReg;
                        rw_l      <= RegWrite;
                    end else if (illegal) begin
                        mem_err <= 1'b1;
                    end else if (rtype_wb) begin
                        wb_en   <= 1'b1;
                        wb_reg  <= dest_reg;
                        wb_data <= alu_result;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!mem_we && rw_l) begin
                            wb_en   <= 1'b1;
                            wb_reg  <= dest_l;
                            wb_data <= m2r_l ? mem_rdata : mem_addr;
                        end
                    end else if (abort) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, R-type write-back,
// illegal accesses, timeout abort and asynchronous reset.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mem_err;

    int n_tests;
    int n_fail;

    dmem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .alu_result (alu_result),
        .store_data (store_data),
        .dest_reg   (dest_reg),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_valid   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        alu_result = '0;
        store_data = '0;
        dest_reg   = '0;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
        ex_valid   = 1'b1;
        MemRead    = mr;
        MemWrite   = mw;
        MemtoReg   = m2r;
        RegWrite   = rw;
        alu_result = addr;
        store_data = sd;
        dest_reg   = rd;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        clear_in();
        #2;
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_wb_en", 32'(wb_en), 32'd0);
        check_eq("rst_wb_reg", 32'(wb_reg), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // lw 0x10 -> r8, ready on third request cycle
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd8);
        #1;
        check_eq("lw_accept_stall", 32'(stall), 32'd1);
        tick();
        // R-type presented during ACCESS must be ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 5'd1);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            check_eq($sformatf("lw_req_c%0d", c), 32'(mem_req), 32'd1);
            check_eq($sformatf("lw_we_c%0d", c), 32'(mem_we), 32'd0);
            check_eq($sformatf("lw_addr_c%0d", c), mem_addr, 32'h10);
            check_eq($sformatf("lw_stall_c%0d", c), 32'(stall), (c == 3) ? 32'd0 : 32'd1);
            check_eq($sformatf("lw_wb_en_c%0d", c), 32'(wb_en), 32'd0);
            tick();
            clear_in();
        end
        mem_ready = 1'b0;
        check_eq("lw_req_done", 32'(mem_req), 32'd0);
        check_eq("lw_wb_en", 32'(wb_en), 32'd1);
        check_eq("lw_wb_reg", 32'(wb_reg), 32'd8);
        check_eq("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        tick();
        check_eq("lw_wb_en_pulse", 32'(wb_en), 32'd0);

        // sw 0x20, ready with first request cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1234_5678, 5'd0);
        #1;
        check_eq("sw_accept_stall", 32'(stall), 32'd1);
        tick();
        clear_in();
        mem_ready = 1'b1;
        #1;
        check_eq("sw_req", 32'(mem_req), 32'd1);
        check_eq("sw_we", 32'(mem_we), 32'd1);
        check_eq("sw_addr", mem_addr, 32'h20);
        check_eq("sw_wdata", mem_wdata, 32'h1234_5678);
        check_eq("sw_stall", 32'(stall), 32'd0);
        tick();
        mem_ready = 1'b0;
        check_eq("sw_req_done", 32'(mem_req), 32'd0);
        check_eq("sw_wb_en", 32'(wb_en), 32'd0);
        check_eq("sw_err", 32'(mem_err), 32'd0);

        // R-type: alu 0x55 -> r3, MemtoReg ignored
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h0, 5'd3);
        #1;
        check_eq("rt_stall", 32'(stall), 32'd0);
        tick();
        clear_in();
        check_eq("rt_wb_en", 32'(wb_en), 32'd1);
        check_eq("rt_wb_data", wb_data, 32'h55);
        check_eq("rt_wb_reg", 32'(wb_reg), 32'd3);
        check_eq("rt_req", 32'(mem_req), 32'd0);
        tick();
        check_eq("rt_wb_en_pulse", 32'(wb_en), 32'd0);
        check_eq("rt_wb_data_hold", wb_data, 32'h55);

        // Misaligned lw and MemRead&MemWrite: error pulse, no request
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd4);
            else        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd4);
            #1;
            check_eq($sformatf("bad%0d_stall", k), 32'(stall), 32'd0);
            tick();
            clear_in();
            check_eq($sformatf("bad%0d_err", k), 32'(mem_err), 32'd1);
            check_eq($sformatf("bad%0d_req", k), 32'(mem_req), 32'd0);
            check_eq($sformatf("bad%0d_wb_en", k), 32'(wb_en), 32'd0);
            tick();
            check_eq($sformatf("bad%0d_err_pulse", k), 32'(mem_err), 32'd0);
            check_eq($sformatf("bad%0d_req2", k), 32'(mem_req), 32'd0);
        end

        // lw with MemtoReg=0: write-back carries the address
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 5'd9);
        tick();
        clear_in();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ready = 1'b0;
        check_eq("lwa_wb_en", 32'(wb_en), 32'd1);
        check_eq("lwa_wb_data", wb_data, 32'h30);
        check_eq("lwa_wb_reg", 32'(wb_reg), 32'd9);

        // Timeout: ready never arrives -> abort after 16 request cycles
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd5);
        tick();
        clear_in();
        for (int c = 1; c <= 16; c++) begin
            #1;
            check_eq($sformatf("to_req_c%0d", c), 32'(mem_req), 32'd1);
            check_eq($sformatf("to_stall_c%0d", c), 32'(stall), (c == 16) ? 32'd0 : 32'd1);
            check_eq($sformatf("to_err_c%0d", c), 32'(mem_err), 32'd0);
            tick();
        end
        check_eq("to_req_drop", 32'(mem_req), 32'd0);
        check_eq("to_err", 32'(mem_err), 32'd1);
        check_eq("to_wb_en", 32'(wb_en), 32'd0);
        tick();
        check_eq("to_err_pulse", 32'(mem_err), 32'd0);

        // Ready on the 16th cycle wins over the abort
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h84, 32'h0, 5'd6);
        tick();
        clear_in();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hCAFE_0001;
            end
            #1;
            check_eq($sformatf("tr_req_c%0d", c), 32'(mem_req), 32'd1);
            check_eq($sformatf("tr_stall_c%0d", c), 32'(stall), (c == 16) ? 32'd0 : 32'd1);
            tick();
        end
        mem_ready = 1'b0;
        check_eq("tr_req_drop", 32'(mem_req), 32'd0);
        check_eq("tr_err", 32'(mem_err), 32'd0);
        check_eq("tr_wb_en", 32'(wb_en), 32'd1);
        check_eq("tr_wb_reg", 32'(wb_reg), 32'd6);
        check_eq("tr_wb_data", wb_data, 32'hCAFE_0001);
        tick();

        // Asynchronous reset during ACCESS drops mem_req immediately
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h90, 32'h0, 5'd7);
        tick();
        clear_in();
        check_eq("ar_req_before", 32'(mem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_req", 32'(mem_req), 32'd0);
        check_eq("ar_stall", 32'(stall), 32'd0);
        check_eq("ar_addr", mem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_eq("ar_req_after", 32'(mem_req), 32'd0);
        check_eq("ar_wb_en_after", 32'(wb_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
